// File: rtl/rf_wb_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_pkg
//   Shared types and constants for the register-file write-back slice.
//
//   RF_NREGS   number of architectural registers (width of the busy mask)
//   RF_ADDR_W  canonical register index width
//   RF_DATA_W  canonical result width
//   RF_ZERO    index of the hard-wired zero register
//   rf_wr_t    one pending register write {addr, data}
//   wb_src_e   which source owns the write port in a given cycle
// -----------------------------------------------------------------------------
package rf_wb_pkg;

    localparam int unsigned RF_NREGS  = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;

    localparam logic [RF_ADDR_W-1:0] RF_ZERO = 5'd0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_LL   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// -----------------------------------------------------------------------------
// rf_wb_fifo
//   Small FIFO that holds long-latency results until the write port is free.
//   Entries are register writes (rf_wr_t by default; the top passes its own
//   width-matched struct). Pointers and occupancy reset asynchronously; the
//   storage array is not reset since an empty FIFO never exposes it.
//
//   Parameters
//     DEPTH      number of entries (power of two, >= 2)
//     entry_t    entry type
//   Ports
//     CLK        clock
//     RESET      asynchronous, active-high reset
//     PUSH       write PUSH_DATA (ignored while FULL)
//     PUSH_DATA  entry to enqueue
//     POP        drop the head entry (ignored while EMPTY)
//     HEAD       current head entry (valid when !EMPTY)
//     FULL       no free entry
//     EMPTY      no stored entry
// -----------------------------------------------------------------------------
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = rf_wr_t
) (
    input  logic   CLK,
    input  logic   RESET,
    input  logic   PUSH,
    input  entry_t PUSH_DATA,
    input  logic   POP,
    output entry_t HEAD,
    output logic   FULL,
    output logic   EMPTY
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign FULL    = (count == (PTR_W+1)'(DEPTH));
    assign EMPTY   = (count == '0);
    assign do_push = PUSH & ~FULL;
    assign do_pop  = POP & ~EMPTY;
    assign HEAD    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= PUSH_DATA;
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// -----------------------------------------------------------------------------
// rf_write_ctrl
//   Write-side front end of the register file. Merges the single-cycle ALU
//   result stream with a buffered long-latency (load / mul-div) stream and
//   issues at most one registered write per cycle on the regfile write port.
//   The ALU always wins the port; long-latency results wait in rf_wb_fifo.
//   Writes to r0 are consumed like any other write but never raise WE.
//
//   Optional feature (macro RF_SCOREBOARD_EN):
//     Defined     - BUSY_MASK tracks registers with an outstanding long-latency
//                   write; ISSUE_LL sets a bit, the matching write clears it in
//                   the cycle it appears on WE; set wins on a same-cycle clash.
//                   An ALU write to a busy register trips a simulation assertion.
//     Not defined - BUSY_MASK is constant zero and ISSUE_LL/ISSUE_ADDR are unused.
//
//   Ports
//     CLK         clock, all state on posedge
//     RESET       asynchronous, active-high reset
//     ALU_VALID   ALU result present this cycle (never back-pressured)
//     ALU_ADDR    ALU destination register
//     ALU_DATA    ALU result
//     LL_VALID    long-latency result offered
//     LL_ADDR     long-latency destination
//     LL_DATA     long-latency result
//     LL_READY    buffer has room; transfer = LL_VALID & LL_READY
//     ISSUE_LL    long-latency op issued this cycle
//     ISSUE_ADDR  destination of the issued long-latency op
//     WR_ADDR_3   registered regfile write address
//     W_DATA      registered regfile write data
//     WE          registered regfile write enable
//     BUSY_MASK   bit i set = r<i> has an outstanding long-latency write
// -----------------------------------------------------------------------------
module rf_write_ctrl
    import rf_wb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LL_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ALU_VALID,
    input  logic [ADDR_W-1:0]   ALU_ADDR,
    input  logic [DATA_W-1:0]   ALU_DATA,
    input  logic                LL_VALID,
    input  logic [ADDR_W-1:0]   LL_ADDR,
    input  logic [DATA_W-1:0]   LL_DATA,
    output logic                LL_READY,
    input  logic                ISSUE_LL,
    input  logic [ADDR_W-1:0]   ISSUE_ADDR,
    output logic [ADDR_W-1:0]   WR_ADDR_3,
    output logic [DATA_W-1:0]   W_DATA,
    output logic                WE,
    output logic [RF_NREGS-1:0] BUSY_MASK
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(RF_ZERO);

    wr_t     alu_wr;
    wr_t     ll_wr;
    wr_t     head_wr;
    wr_t     sel_wr;
    wb_src_e sel_src;
    logic    fifo_full;
    logic    fifo_empty;
    logic    ll_push;
    logic    ll_pop;

    assign alu_wr = '{addr: ALU_ADDR, data: ALU_DATA};
    assign ll_wr  = '{addr: LL_ADDR,  data: LL_DATA};

    // Readiness depends only on occupancy, never on this cycle's pop, so the
    // producer sees no combinational path from ALU_VALID.
    assign LL_READY = ~fifo_full;
    assign ll_push  = LL_VALID & LL_READY;

    rf_wb_fifo #(
        .DEPTH   (LL_DEPTH),
        .entry_t (wr_t)
    ) u_ll_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .PUSH      (ll_push),
        .PUSH_DATA (ll_wr),
        .POP       (ll_pop),
        .HEAD      (head_wr),
        .FULL      (fifo_full),
        .EMPTY     (fifo_empty)
    );

    // Port arbitration: ALU first, then the buffered head, else idle.
    always_comb begin
        sel_src = WB_SRC_NONE;
        sel_wr  = head_wr;
        if (ALU_VALID) begin
            sel_src = WB_SRC_ALU;
            sel_wr  = alu_wr;
        end else if (!fifo_empty) begin
            sel_src = WB_SRC_LL;
            sel_wr  = head_wr;
        end
    end

    assign ll_pop = (sel_src == WB_SRC_LL);

    // Address/data hold when idle; a selected r0 write updates them but keeps
    // WE low so the zero register is never written.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WE        <= 1'b0;
            WR_ADDR_3 <= '0;
            W_DATA    <= '0;
        end else if (sel_src != WB_SRC_NONE) begin
            WE        <= (sel_wr.addr != ZERO_REG);
            WR_ADDR_3 <= sel_wr.addr;
            W_DATA    <= sel_wr.data;
        end else begin
            WE        <= 1'b0;
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [RF_NREGS-1:0] busy_q;
    logic [RF_NREGS-1:0] busy_set;
    logic [RF_NREGS-1:0] busy_clr;

    // The clear is taken from the write being loaded into the output register,
    // so the bit drops in the same cycle the write is visible on WE.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (ISSUE_LL && (ISSUE_ADDR != ZERO_REG)) begin
            busy_set[ISSUE_ADDR] = 1'b1;
        end
        if (ll_pop) begin
            busy_clr[head_wr.addr] = 1'b1;
        end
    end

    // Set is applied after clear: a newly issued op to the same register wins.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~busy_clr) | busy_set;
        end
    end

    assign BUSY_MASK = busy_q;

    alu_write_to_busy_reg: assert property (
        @(posedge CLK) disable iff (RESET)
        !(ALU_VALID && (ALU_ADDR != ZERO_REG) && busy_q[ALU_ADDR])
    );
`else
    logic unused_issue;

    assign unused_issue = ^{ISSUE_LL, ISSUE_ADDR};
    assign BUSY_MASK    = '0;
`endif

endmodule

// File: tb/tb_rf_write_ctrl.sv
module tb_rf_write_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ALU_VALID;
    logic [AW-1:0] ALU_ADDR;
    logic [DW-1:0] ALU_DATA;
    logic          LL_VALID;
    logic [AW-1:0] LL_ADDR;
    logic [DW-1:0] LL_DATA;
    logic          LL_READY;
    logic          ISSUE_LL;
    logic [AW-1:0] ISSUE_ADDR;
    logic [AW-1:0] WR_ADDR_3;
    logic [DW-1:0] W_DATA;
    logic          WE;
    logic [31:0]   BUSY_MASK;

    rf_write_ctrl #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .LL_DEPTH (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ALU_VALID  (ALU_VALID),
        .ALU_ADDR   (ALU_ADDR),
        .ALU_DATA   (ALU_DATA),
        .LL_VALID   (LL_VALID),
        .LL_ADDR    (LL_ADDR),
        .LL_DATA    (LL_DATA),
        .LL_READY   (LL_READY),
        .ISSUE_LL   (ISSUE_LL),
        .ISSUE_ADDR (ISSUE_ADDR),
        .WR_ADDR_3  (WR_ADDR_3),
        .W_DATA     (W_DATA),
        .WE         (WE),
        .BUSY_MASK  (BUSY_MASK)
    );

    always #5 CLK = ~CLK;

    // Reference model: a plain queue for the buffer plus the expected port state.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [31:0]   m_busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          lv;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_busy = '0;
    endtask

    // Drive one cycle of inputs, advance the model, then compare just after the edge.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                        input logic iv, input logic [AW-1:0] ia);
        ent_t        e;
        logic        sel;
        logic        acc;
        logic [31:0] clr;
        ALU_VALID  = av;
        ALU_ADDR   = aa;
        ALU_DATA   = ad;
        LL_VALID   = lv;
        LL_ADDR    = la;
        LL_DATA    = ld;
        ISSUE_LL   = iv;
        ISSUE_ADDR = ia;

        sel    = 1'b0;
        clr    = '0;
        e.addr = '0;
        e.data = '0;
        acc    = lv && (mq.size() < DEPTH);
        if (av) begin
            sel    = 1'b1;
            e.addr = aa;
            e.data = ad;
        end else if (mq.size() > 0) begin
            e   = mq.pop_front();
            sel = 1'b1;
            clr[e.addr] = 1'b1;
        end
        if (acc) mq.push_back('{addr: la, data: ld});
        m_we = sel && (e.addr != 0);
        if (sel) begin
            m_addr = e.addr;
            m_data = e.data;
        end
`ifdef RF_SCOREBOARD_EN
        begin
            logic [31:0] set;
            set = '0;
            if (iv && ia != 0) set[ia] = 1'b1;
            m_busy = (m_busy & ~clr) | set;
        end
`endif

        @(posedge CLK);
        #1;
        chk("we", {31'd0, WE}, {31'd0, m_we});
        if (m_we) begin
            chk("wr_addr", {27'd0, WR_ADDR_3}, {27'd0, m_addr});
            chk("w_data", W_DATA, m_data);
        end
        chk("ll_ready", {31'd0, LL_READY}, {31'd0, mq.size() < DEPTH});
        chk("busy_mask", BUSY_MASK, m_busy);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] pend[$];

        // Hand-written vectors: inputs for one cycle, expected port state after the edge.
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0};
        tbl[2]  = '{1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h00000033};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'h0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h1234};
        tbl[5]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd9, 32'h1234, 1'b1, 5'd1, 32'h11};
        tbl[6]  = '{1'b1, 5'd2, 32'h22,       1'b0, 5'd0, 32'h0,    1'b1, 5'd2, 32'h22};
        tbl[7]  = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'h44};
        tbl[8]  = '{1'b1, 5'd6, 32'h66,       1'b0, 5'd0, 32'h0,    1'b1, 5'd6, 32'h66};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h1234};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0};

        RESET      = 1'b1;
        ALU_VALID  = 1'b0;
        ALU_ADDR   = '0;
        ALU_DATA   = '0;
        LL_VALID   = 1'b0;
        LL_ADDR    = '0;
        LL_DATA    = '0;
        ISSUE_LL   = 1'b0;
        ISSUE_ADDR = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_we", {31'd0, WE}, 32'd0);
        chk("rst_addr", {27'd0, WR_ADDR_3}, 32'd0);
        chk("rst_data", W_DATA, 32'd0);
        chk("rst_ready", {31'd0, LL_READY}, 32'd1);
        chk("rst_busy", BUSY_MASK, 32'd0);
        RESET = 1'b0;

        // ALU latency, r0 suppression, LL latency and ALU priority.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld, 1'b0, '0);
            chk($sformatf("tbl%0d_we", i), {31'd0, WE}, {31'd0, tbl[i].ewe});
            if (tbl[i].ewe) begin
                chk($sformatf("tbl%0d_addr", i), {27'd0, WR_ADDR_3}, {27'd0, tbl[i].ea});
                chk($sformatf("tbl%0d_data", i), W_DATA, tbl[i].ed);
            end
        end

        // Fill the buffer while the ALU owns the port, then drain it.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'(20 + i), 32'hC0 + i, 1'b1, 5'(10 + i), 32'hA0 + i, 1'b0, '0);
        end
        chk("fill_ready_low", {31'd0, LL_READY}, 32'd0);
        step(1'b1, 5'd24, 32'hC4, 1'b1, 5'd14, 32'hA4, 1'b0, '0);
        chk("full_reject_ready", {31'd0, LL_READY}, 32'd0);
        chk("full_alu_addr", {27'd0, WR_ADDR_3}, 32'd24);
        idle();
        chk("drain0_ready", {31'd0, LL_READY}, 32'd1);
        chk("drain0_addr", {27'd0, WR_ADDR_3}, 32'd10);
        chk("drain0_data", W_DATA, 32'hA0);
        for (int i = 1; i < 4; i++) begin
            idle();
            chk($sformatf("drain%0d_we", i), {31'd0, WE}, 32'd1);
            chk($sformatf("drain%0d_addr", i), {27'd0, WR_ADDR_3}, 32'(10 + i));
        end
        idle();
        chk("drain_done_we", {31'd0, WE}, 32'd0);

`ifdef RF_SCOREBOARD_EN
        // Busy tracking: set, clear with the write, set winning over clear.
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        chk("sb_set", {31'd0, BUSY_MASK[7]}, 32'd1);
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'h77, 1'b0, '0);
        chk("sb_hold", {31'd0, BUSY_MASK[7]}, 32'd1);
        idle();
        chk("sb_clr_we", {31'd0, WE}, 32'd1);
        chk("sb_clr", {31'd0, BUSY_MASK[7]}, 32'd0);
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'h78, 1'b1, 5'd7);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        chk("sb_win_we", {31'd0, WE}, 32'd1);
        chk("sb_win", {31'd0, BUSY_MASK[7]}, 32'd1);
`endif

        // Asynchronous reset with three buffered entries.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'(20 + i), 32'hE0 + i, 1'b1, 5'(15 + i), 32'hB0 + i, 1'b1, 5'(15 + i));
        end
        ALU_VALID = 1'b0;
        LL_VALID  = 1'b0;
        ISSUE_LL  = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        chk("arst_we", {31'd0, WE}, 32'd0);
        chk("arst_ready", {31'd0, LL_READY}, 32'd1);
        chk("arst_busy", BUSY_MASK, 32'd0);
        chk("arst_addr", {27'd0, WR_ADDR_3}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            chk($sformatf("post_rst%0d_we", i), {31'd0, WE}, 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic          av, lv, iv, acc, from_pend;
            logic [AW-1:0] aa, la, ia;
            av = ($urandom_range(0, 99) < 55);
            aa = AW'($urandom_range(0, 31));
            for (int k = 0; k < 64 && m_busy[aa]; k++) aa = AW'($urandom_range(0, 31));
            if (m_busy[aa]) aa = '0;
            lv = ($urandom_range(0, 99) < 50);
            from_pend = (pend.size() > 0);
            la = from_pend ? pend[0] : AW'($urandom_range(0, 31));
            acc = lv && (mq.size() < DEPTH);
            if (acc && from_pend) void'(pend.pop_front());
            iv = ($urandom_range(0, 99) < 15) && (pend.size() < 4);
            ia = AW'($urandom_range(1, 31));
            if (iv) pend.push_back(ia);
            step(av, aa, $urandom, lv, la, $urandom, iv, ia);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
